// File: rtl/up_expand.sv
`default_nettype none
// ============================================================================
// Module   : up_expand
// Purpose  : Expands (value, run) tokens back into 8-byte rows for the
//            inverse transform row loader. Rows are presented on y1..y8
//            under a valid/ready handshake.
// Options  : UP_EXPAND_SPILL_EN - when defined, run bytes past position 7
//            carry into the next row; when undefined they are dropped and
//            trunc pulses for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module up_expand #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_run,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y1,
  output logic [DW-1:0] y2,
  output logic [DW-1:0] y3,
  output logic [DW-1:0] y4,
  output logic [DW-1:0] y5,
  output logic [DW-1:0] y6,
  output logic [DW-1:0] y7,
  output logic [DW-1:0] y8,
  output logic          trunc
);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    ptr_q,   ptr_d;
  logic [3:0]    rem_q,   rem_d;
  logic [DW-1:0] val_q,   val_d;
  logic          last_q,  last_d;
  logic          trunc_q, trunc_d;
  logic [DW-1:0] row_q [8];
  logic [DW-1:0] row_d [8];
  logic [3:0]    rem_dec;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign trunc     = trunc_q;

  assign y1 = row_q[0];
  assign y2 = row_q[1];
  assign y3 = row_q[2];
  assign y4 = row_q[3];
  assign y5 = row_q[4];
  assign y6 = row_q[5];
  assign y7 = row_q[6];
  assign y8 = row_q[7];

  // Next-state logic: token capture, one byte written per EXPAND cycle, row hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    val_d   = val_q;
    last_d  = last_q;
    trunc_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      row_d[i] = row_q[i];
    end
    // Padding runs with rem already at 0, so saturate rather than wrap.
    rem_dec = (rem_q != 4'd0) ? (rem_q - 4'd1) : 4'd0;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          val_d   = in_data;
          rem_d   = {1'b0, in_run} + 4'd1;
          last_d  = in_last;
          state_d = EXPAND;
        end
      end

      EXPAND: begin
        row_d[ptr_q] = val_q;
        ptr_d        = ptr_q + 3'd1;
        rem_d        = rem_dec;
        if (ptr_q == 3'd7) begin
          // A full row always goes to HOLD, even if the token ended exactly here.
          state_d = HOLD;
`ifdef UP_EXPAND_SPILL_EN
          // Leftover run bytes stay in rem and resume after the row is released.
`else
          if (rem_dec != 4'd0) begin
            rem_d   = 4'd0;
            trunc_d = 1'b1;
          end
`endif
        end else if ((rem_dec == 4'd0) && !last_q) begin
          state_d = FILL;
        end
        // Otherwise keep expanding: either run bytes remain or the last
        // token pads the rest of the row with its value.
      end

      HOLD: begin
        if (out_ready) begin
          ptr_d = 3'd0;
          if (rem_q != 4'd0) begin
            state_d = EXPAND;
          end else begin
            state_d = FILL;
            last_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or held row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      ptr_q   <= 3'd0;
      rem_q   <= 4'd0;
      val_q   <= '0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      val_q   <= val_d;
      last_q  <= last_d;
      trunc_q <= trunc_d;
      for (int i = 0; i < 8; i++) begin
        row_q[i] <= row_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_up_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_expand
// Purpose  : Directed self-checking bench for up_expand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_expand;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_run;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y1, y2, y3, y4, y5, y6, y7, y8;
  logic       trunc;
  logic [63:0] row;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  assign row = {y1, y2, y3, y4, y5, y6, y7, y8};

  up_expand #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_run    (in_run),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .y5        (y5),
    .y6        (y6),
    .y7        (y7),
    .y8        (y8),
    .trunc     (trunc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples change 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one token, waiting a bounded time for in_ready.
  task automatic send_token(input logic [7:0] d, input logic [2:0] r, input logic l);
    int i;
    for (i = 0; i < 50; i++) begin
      if (in_ready) break;
      tick();
    end
    if (i == 50) begin
      total++;
      bad++;
      $error("FAIL send_timeout: in_ready never rose, got 0 expected 1");
    end
    in_valid = 1'b1;
    in_data  = d;
    in_run   = r;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Cycles until out_valid rises; -1 if it never does within the bound.
  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic release_row();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_run    = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_trunc",     64'(trunc),     64'd0);
    check("rst_row",       row,            64'd0);

    // Eight single-byte tokens with out_ready held high
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send_token(8'(k), 3'd0, 1'b0);
    end
    wait_valid(n);
    check("t1_latency",    64'(n),         64'd1);
    check("t1_row",        row,            64'h0102030405060708);
    tick();
    check("t1_valid_drop", 64'(out_valid), 64'd0);
    check("t1_ready_back", 64'(in_ready),  64'd1);
    out_ready = 1'b0;

    // One run-8 token
    send_token(8'h55, 3'd7, 1'b0);
    check("t2_ready_low",  64'(in_ready),  64'd0);
    wait_valid(n);
    check("t2_latency",    64'(n),         64'd8);
    check("t2_row",        row,            64'h5555555555555555);
    check("t2_ready_hold", 64'(in_ready),  64'd0);
    release_row();
    check("t2_valid_drop", 64'(out_valid), 64'd0);
    check("t2_ready_back", 64'(in_ready),  64'd1);

    // Two run-5 tokens overflowing the row
    send_token(8'hAA, 3'd4, 1'b0);
    send_token(8'hBB, 3'd4, 1'b0);
    wait_valid(n);
    check("t3_row",        row,            64'hAAAAAAAAAABBBBBB);
`ifdef UP_EXPAND_SPILL_EN
    check("t3_trunc",      64'(trunc),     64'd0);
    release_row();
    check("t3_spill_busy", 64'(in_ready),  64'd0);
    tick();
    tick();
    check("t3_spill_rdy",  64'(in_ready),  64'd1);
    check("t3_spill_row",  64'({y1, y2}),  64'hBBBB);
    check("t3_trunc_quiet", 64'(trunc),    64'd0);
    send_token(8'h5A, 3'd5, 1'b0);
    wait_valid(n);
    check("t3_flush_row",  row,            64'hBBBB5A5A5A5A5A5A);
    release_row();
`else
    check("t3_trunc",      64'(trunc),     64'd1);
    tick();
    check("t3_trunc_pulse", 64'(trunc),    64'd0);
    check("t3_still_hold", 64'(out_valid), 64'd1);
    release_row();
    check("t3_ready_back", 64'(in_ready),  64'd1);
    check("t3_no_spill",   64'(out_valid), 64'd0);
`endif

    // Last token padding the row
    send_token(8'h10, 3'd1, 1'b1);
    wait_valid(n);
    check("t4_latency",    64'(n),         64'd8);
    check("t4_row",        row,            64'h1010101010101010);
    release_row();
    check("t4_ready_back", 64'(in_ready),  64'd1);

    // Row completing exactly as the run ends, token accepted at ptr 7
    send_token(8'h01, 3'd6, 1'b0);
    send_token(8'h77, 3'd0, 1'b0);
    wait_valid(n);
    check("t5_latency",    64'(n),         64'd1);
    check("t5_row",        row,            64'h0101010101010177);
    check("t5_trunc",      64'(trunc),     64'd0);
    release_row();

    // Held row with out_ready low and in_valid asserted
    send_token(8'h66, 3'd7, 1'b0);
    wait_valid(n);
    in_valid = 1'b1;
    in_data  = 8'h99;
    in_run   = 3'd2;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t6_hold_valid", 64'(out_valid), 64'd1);
      check("t6_hold_ready", 64'(in_ready),  64'd0);
      check("t6_hold_row",   row,            64'h6666666666666666);
    end
    in_valid = 1'b0;
    release_row();
    check("t6_ready_back", 64'(in_ready),  64'd1);
    tick();
    check("t6_no_accept",  64'(in_ready),  64'd1);

    // Reset mid-EXPAND at ptr 3
    send_token(8'h44, 3'd7, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_row",        row,            64'd0);
    check("t7_out_valid",  64'(out_valid), 64'd0);
    check("t7_in_ready",   64'(in_ready),  64'd1);
    check("t7_trunc",      64'(trunc),     64'd0);
    send_token(8'h22, 3'd7, 1'b0);
    wait_valid(n);
    check("t7_latency",    64'(n),         64'd8);
    check("t7_row_after",  row,            64'h2222222222222222);
    release_row();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
